// File: rtl/trace_rule_matcher_if.sv
// Trace byte stream in, per-packet compare result out.
// Result signals are driven by the matcher; trace signals by the capture front-end.
// No backpressure: one byte may be presented every cycle.
interface trace_rule_matcher_if #(
  parameter int pNUM_RULES = 8
);
  logic [7:0]            trace_data;
  logic                  trace_valid;
  logic                  trace_start;
  logic                  trace_last;
  logic                  match_valid;
  logic [pNUM_RULES-1:0] match_hits;
  logic [2:0]            match_rule;

  modport master (
    output trace_data, trace_valid, trace_start, trace_last,
    input  match_valid, match_hits, match_rule
  );

  modport slave (
    input  trace_data, trace_valid, trace_start, trace_last,
    output match_valid, match_hits, match_rule
  );
endinterface

// File: rtl/trace_rule_matcher.sv
// Packet assembly (up to pRULE_BYTES bytes) and pattern/mask compare against pNUM_RULES rules.
// Latency: result registered one cycle after the last byte is accepted.
// No backpressure: a byte is accepted every cycle trace_valid is high.
module trace_rule_matcher #(
  parameter int pNUM_RULES   = 8,
  parameter int pRULE_BYTES  = 8,
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                                trace_clk_i,
  input  logic                                reset_i,
  trace_rule_matcher_if.slave                 trace_if,
  input  logic [pNUM_RULES*8*pRULE_BYTES-1:0] pattern_flat_i,
  input  logic [pNUM_RULES*8*pRULE_BYTES-1:0] mask_flat_i,
  input  logic [pNUM_RULES-1:0]               pattern_enable_i,
  input  logic                                arm_i,
  input  logic                                clear_count_i,
  output logic                                trigger_out_o,
  output logic                                armed_o,
  output logic [pCOUNT_WIDTH-1:0]             match_count_o
);

  localparam int VW    = 8 * pRULE_BYTES;
  localparam int IDX_W = $clog2(pRULE_BYTES + 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [VW-1:0]           buf_q, buf_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pkt_done;

  logic [pNUM_RULES-1:0]   hit_d;
  logic [2:0]              rule_d;
  logic                    any_hit;

  logic                    match_valid_q;
  logic [pNUM_RULES-1:0]   match_hits_q;
  logic [2:0]              match_rule_q;
  logic                    trigger_q;
  logic                    armed_q;
  logic [pCOUNT_WIDTH-1:0] match_count_q;

  // Assembly state, buffer and byte index.
  always_ff @(posedge trace_clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  // Packet assembly: start always restarts, bytes past the buffer are dropped, last closes the packet.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    pkt_done = 1'b0;
    if (trace_if.trace_valid) begin
      if (trace_if.trace_start) begin
        buf_d   = {trace_if.trace_data, {(VW-8){1'b0}}};
        idx_d   = IDX_W'(1);
        state_d = ST_COLLECT;
        if (trace_if.trace_last) begin
          pkt_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end else if (state_q == ST_COLLECT) begin
        for (int b = 0; b < pRULE_BYTES; b++) begin
          if (idx_q == IDX_W'(b)) begin
            buf_d[VW-8-8*b +: 8] = trace_if.trace_data;
          end
        end
        if (idx_q < IDX_W'(pRULE_BYTES)) begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (trace_if.trace_last) begin
          pkt_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    end
  end

  // Per-rule compare on the packet as it stands including this cycle's byte.
  always_comb begin
    hit_d = '0;
    for (int r = 0; r < pNUM_RULES; r++) begin
      hit_d[r] = pattern_enable_i[r] &
                 (((buf_d ^ pattern_flat_i[r*VW +: VW]) & ~mask_flat_i[r*VW +: VW]) == '0);
    end
  end

  // Lowest-index hitting rule; zero when nothing hits.
  always_comb begin
    rule_d = '0;
    for (int r = pNUM_RULES - 1; r >= 0; r--) begin
      if (hit_d[r]) begin
        rule_d = 3'(r);
      end
    end
  end

  assign any_hit = |hit_d;

  // Registered results, one-shot trigger (arm beats the clearing match) and saturating counter.
  always_ff @(posedge trace_clk_i) begin
    if (reset_i) begin
      match_valid_q <= 1'b0;
      match_hits_q  <= '0;
      match_rule_q  <= '0;
      trigger_q     <= 1'b0;
      armed_q       <= 1'b0;
      match_count_q <= '0;
    end else begin
      match_valid_q <= pkt_done;
      if (pkt_done) begin
        match_hits_q <= hit_d;
        match_rule_q <= rule_d;
      end
      trigger_q <= pkt_done & any_hit & armed_q;
      if (arm_i) begin
        armed_q <= 1'b1;
      end else if (pkt_done & any_hit & armed_q) begin
        armed_q <= 1'b0;
      end
      if (clear_count_i) begin
        match_count_q <= '0;
      end else if (pkt_done & any_hit & (match_count_q != '1)) begin
        match_count_q <= match_count_q + pCOUNT_WIDTH'(1);
      end
    end
  end

  assign trace_if.match_valid = match_valid_q;
  assign trace_if.match_hits  = match_hits_q;
  assign trace_if.match_rule  = match_rule_q;
  assign trigger_out_o        = trigger_q;
  assign armed_o              = armed_q;
  assign match_count_o        = match_count_q;

endmodule

// File: tb/tb_trace_rule_matcher.sv
// Bench for trace_rule_matcher: vector table, directed corner sequences, random traffic
// checked every cycle against a packet-level reference model.
module tb_trace_rule_matcher;
  localparam int NR = 8;
  localparam int RB = 8;
  localparam int CW = 16;

  logic            trace_clk = 1'b0;
  logic            reset;
  logic [NR*64-1:0] pattern_flat;
  logic [NR*64-1:0] mask_flat;
  logic [NR-1:0]   pattern_enable;
  logic            arm;
  logic            clear_count;
  logic            trigger_out;
  logic            armed;
  logic [CW-1:0]   match_count;

  always #5 trace_clk = ~trace_clk;

  trace_rule_matcher_if #(.pNUM_RULES(NR)) bus ();

  trace_rule_matcher #(
    .pNUM_RULES(NR), .pRULE_BYTES(RB), .pCOUNT_WIDTH(CW)
  ) dut (
    .trace_clk_i      (trace_clk),
    .reset_i          (reset),
    .trace_if         (bus),
    .pattern_flat_i   (pattern_flat),
    .mask_flat_i      (mask_flat),
    .pattern_enable_i (pattern_enable),
    .arm_i            (arm),
    .clear_count_i    (clear_count),
    .trigger_out_o    (trigger_out),
    .armed_o          (armed),
    .match_count_o    (match_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mv_seen  = 0;
  bit chk_en   = 1'b1;

  // rule registers as the model sees them
  logic [63:0] pat [NR];
  logic [63:0] msk [NR];

  // reference model state
  logic [7:0]    m_pkt [$];
  bit            m_inpkt;
  bit            m_mv, m_trig, m_armed;
  logic [NR-1:0] m_hits;
  logic [2:0]    m_rule;
  logic [CW-1:0] m_cnt;

  typedef struct {
    bit          arm;
    bit          vld;
    bit          st;
    bit          ls;
    logic [7:0]  dat;
    bit          mv;
    logic [7:0]  hits;
    logic [2:0]  rule;
    bit          trig;
    bit          armd;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_rule(input int r, input logic [63:0] p, input logic [63:0] m);
    pat[r] = p;
    msk[r] = m;
    pattern_flat[r*64 +: 64] = p;
    mask_flat[r*64 +: 64]    = m;
  endtask

  task automatic drive(input bit v, input bit s, input bit l, input logic [7:0] d);
    bus.trace_valid = v;
    bus.trace_start = s;
    bus.trace_last  = l;
    bus.trace_data  = d;
  endtask

  // Packet-level behaviour: what one clock edge does given the current inputs.
  task automatic model_update();
    bit done;
    bit any;
    bit found;
    logic [63:0] v;
    if (reset) begin
      m_pkt.delete();
      m_inpkt = 0; m_mv = 0; m_trig = 0; m_armed = 0;
      m_hits = '0; m_rule = '0; m_cnt = '0;
      return;
    end
    done = 0;
    any  = 0;
    if (bus.trace_valid) begin
      if (bus.trace_start) begin
        m_pkt.delete();
        m_pkt.push_back(bus.trace_data);
        m_inpkt = 1;
      end else if (m_inpkt && m_pkt.size() < RB) begin
        m_pkt.push_back(bus.trace_data);
      end
      if (bus.trace_last && m_inpkt) begin
        done = 1;
        m_inpkt = 0;
      end
    end
    m_mv = done;
    if (done) begin
      v = '0;
      for (int i = 0; i < m_pkt.size(); i++) v = v | (64'(m_pkt[i]) << (56 - 8*i));
      found = 0;
      m_rule = '0;
      for (int r = 0; r < NR; r++) begin
        m_hits[r] = pattern_enable[r] && (((v ^ pat[r]) & ~msk[r]) == 64'd0);
        if (m_hits[r] && !found) begin
          found = 1;
          m_rule = 3'(r);
        end
      end
      any = found;
    end
    m_trig = done && any && m_armed;
    if (arm) m_armed = 1;
    else if (m_trig) m_armed = 0;
    if (clear_count) m_cnt = '0;
    else if (done && any && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  // One clock: advance model, let the edge happen, compare on the falling edge.
  task automatic step();
    model_update();
    @(posedge trace_clk);
    @(negedge trace_clk);
    mv_seen += int'(bus.match_valid);
    if (chk_en) begin
      check("match_valid", 64'(bus.match_valid), 64'(m_mv));
      check("match_hits",  64'(bus.match_hits),  64'(m_hits));
      check("match_rule",  64'(bus.match_rule),  64'(m_rule));
      check("trigger_out", 64'(trigger_out),     64'(m_trig));
      check("armed",       64'(armed),           64'(m_armed));
      check("match_count", 64'(match_count),     64'(m_cnt));
    end
  endtask

  task automatic send_pkt(input logic [7:0] b [$]);
    for (int i = 0; i < b.size(); i++) begin
      drive(1, i == 0, i == b.size() - 1, b[i]);
      step();
    end
    drive(0, 0, 0, 8'h00);
  endtask

  initial begin
    int mv0;
    reset = 1; arm = 0; clear_count = 0; pattern_enable = '0;
    pattern_flat = '0; mask_flat = '0;
    for (int r = 0; r < NR; r++) set_rule(r, 64'd0, 64'd0);
    drive(0, 0, 0, 8'h00);
    step();
    step();
    check("rst_match_valid", 64'(bus.match_valid), 64'd0);
    check("rst_hits",        64'(bus.match_hits),  64'd0);
    check("rst_count",       64'(match_count),     64'd0);
    check("rst_armed",       64'(armed),           64'd0);
    reset = 0;

    // ---- table: rule 0 matches 01 02 xx..., armed trigger ----
    tbl[0] = '{1, 0, 0, 0, 8'h00, 0, 8'h00, 3'd0, 0, 1, 16'd0};
    tbl[1] = '{0, 1, 1, 0, 8'h01, 0, 8'h00, 3'd0, 0, 1, 16'd0};
    tbl[2] = '{0, 1, 0, 0, 8'h02, 0, 8'h00, 3'd0, 0, 1, 16'd0};
    tbl[3] = '{0, 1, 0, 1, 8'h03, 1, 8'h01, 3'd0, 1, 0, 16'd1};
    tbl[4] = '{0, 0, 0, 0, 8'h00, 0, 8'h01, 3'd0, 0, 0, 16'd1};
    tbl[5] = '{0, 1, 1, 0, 8'h01, 0, 8'h01, 3'd0, 0, 0, 16'd1};
    tbl[6] = '{0, 1, 0, 1, 8'h05, 1, 8'h00, 3'd0, 0, 0, 16'd1};
    tbl[7] = '{0, 0, 0, 0, 8'h00, 0, 8'h00, 3'd0, 0, 0, 16'd1};
    set_rule(0, 64'h0102000000000000, 64'h0000FFFFFFFFFFFF);
    pattern_enable = 8'h01;
    for (int i = 0; i < 8; i++) begin
      arm = tbl[i].arm;
      drive(tbl[i].vld, tbl[i].st, tbl[i].ls, tbl[i].dat);
      step();
      check($sformatf("tbl%0d_mv", i),    64'(bus.match_valid), 64'(tbl[i].mv));
      check($sformatf("tbl%0d_hits", i),  64'(bus.match_hits),  64'(tbl[i].hits));
      check($sformatf("tbl%0d_rule", i),  64'(bus.match_rule),  64'(tbl[i].rule));
      check($sformatf("tbl%0d_trig", i),  64'(trigger_out),     64'(tbl[i].trig));
      check($sformatf("tbl%0d_armed", i), 64'(armed),           64'(tbl[i].armd));
      check($sformatf("tbl%0d_cnt", i),   64'(match_count),     64'(tbl[i].cnt));
    end
    arm = 0;

    // ---- rules 2 and 5 both hit packet AA ----
    set_rule(2, 64'hAA00000000000000, 64'h00FFFFFFFFFFFFFF);
    set_rule(5, 64'hAA00000000000000, 64'h0000000000000000);
    pattern_enable = 8'h24;
    send_pkt('{8'hAA});
    check("two_rule_hits", 64'(bus.match_hits), 64'h24);
    check("two_rule_rule", 64'(bus.match_rule), 64'd2);
    pattern_enable = 8'h20;
    send_pkt('{8'hAA});
    check("rule5_hits", 64'(bus.match_hits), 64'h20);
    check("rule5_rule", 64'(bus.match_rule), 64'd5);

    // ---- 10-byte packet, only first 8 bytes compared ----
    set_rule(1, 64'h1112131415161718, 64'd0);
    pattern_enable = 8'h02;
    mv0 = mv_seen;
    send_pkt('{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A});
    check("long_pkt_hits", 64'(bus.match_hits), 64'h02);
    step();
    check("long_pkt_one_mv", 64'(mv_seen - mv0), 64'd1);

    // ---- restart mid-packet: first two bytes discarded ----
    mv0 = mv_seen;
    drive(1, 1, 0, 8'h55); step();
    drive(1, 0, 0, 8'h66); step();
    send_pkt('{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18});
    check("restart_hits", 64'(bus.match_hits), 64'h02);
    step();
    check("restart_one_mv", 64'(mv_seen - mv0), 64'd1);

    // ---- reset mid-packet, then normal packet with arm on the triggering cycle ----
    pattern_enable = 8'h01;
    mv0 = mv_seen;
    drive(1, 1, 0, 8'h01); step();
    drive(1, 0, 0, 8'h02); step();
    reset = 1;
    drive(0, 0, 0, 8'h00); step();
    reset = 0;
    check("midrst_hits",  64'(bus.match_hits), 64'd0);
    check("midrst_count", 64'(match_count),    64'd0);
    drive(1, 0, 0, 8'h03); step();
    drive(1, 0, 1, 8'h04); step();
    drive(0, 0, 0, 8'h00); step();
    check("midrst_no_mv", 64'(mv_seen - mv0), 64'd0);
    arm = 1; step(); arm = 0;
    drive(1, 1, 0, 8'h01); step();
    drive(1, 0, 0, 8'h02); step();
    drive(1, 0, 0, 8'h03); step();
    arm = 1;
    drive(1, 0, 1, 8'h04); step();
    arm = 0;
    drive(0, 0, 0, 8'h00);
    check("arm_wins_trig",  64'(trigger_out),      64'd1);
    check("arm_wins_armed", 64'(armed),            64'd1);
    check("post_rst_hits",  64'(bus.match_hits),   64'h01);
    step();

    // ---- random traffic ----
    for (int c = 0; c < 2500; c++) begin
      if (c % 200 == 0) begin
        for (int r = 0; r < NR; r++) begin
          if ($urandom_range(0, 7) == 0)
            set_rule(r, {$urandom, $urandom}, 64'hFFFFFFFFFFFFFFFF);
          else
            set_rule(r, {$urandom, $urandom} & 64'h0101010101010101,
                     {$urandom | $urandom, $urandom | $urandom});
        end
        pattern_enable = 8'($urandom);
      end
      arm         = ($urandom_range(0, 15) == 0);
      clear_count = ($urandom_range(0, 63) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 8'($urandom_range(0, 1)));
      step();
    end
    arm = 0; clear_count = 0; reset = 0;
    drive(0, 0, 0, 8'h00);

    // ---- counter saturation ----
    set_rule(0, 64'd0, 64'hFFFFFFFFFFFFFFFF);
    pattern_enable = 8'h01;
    clear_count = 1; step(); clear_count = 0;
    chk_en = 0;
    drive(1, 1, 1, 8'h5A);
    for (int i = 0; i < 65537; i++) step();
    chk_en = 1;
    drive(0, 0, 0, 8'h00);
    step();
    check("sat_count", 64'(match_count), 64'hFFFF);
    clear_count = 1;
    drive(1, 1, 1, 8'h5A);
    step();
    clear_count = 0;
    drive(0, 0, 0, 8'h00);
    check("clear_beats_inc", 64'(match_count), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
